// File: rtl/ysyx_22050550_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default widths,
// the boot address and the fetch state encoding.
package ysyx_22050550_fetch_ctrl_pkg;

    localparam int unsigned FETCH_PC_W     = 64;
    localparam int unsigned FETCH_INST_W   = 32;
    localparam logic [63:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_DROP = 2'd3
    } fetchState_e;

endpackage

// File: rtl/ysyx_22050550_Reg.sv
// Generic enabled register with a synchronous active-high reset value.
// Used for the fetch PC and the instruction/PC pair handed to decode.
module ysyx_22050550_Reg
    import ysyx_22050550_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_data;

    // Load on enable; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= RESET_VAL;
        end else if (i_wen) begin
            r_data <= i_din;
        end
    end

    assign o_dout = r_data;

endmodule

// File: rtl/ysyx_22050550_fetch_ctrl.sv
// Single-outstanding instruction fetch controller.
// REQ issues a fetch, WAIT collects the response, OUT presents it to decode,
// and DROP swallows a response that a redirect has made stale.
// Optional feature macro: YSYX_22050550_FETCH_MISALIGN_EN adds the
// id_misalign output and turns a misaligned PC into a zero instruction
// flagged as misaligned instead of a memory request.
module ysyx_22050550_fetch_ctrl
    import ysyx_22050550_fetch_ctrl_pkg::*;
#(
    parameter int unsigned      PC_W     = FETCH_PC_W,
    parameter int unsigned      INST_W   = FETCH_INST_W,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    output logic              id_misalign,
`endif
    output logic [INST_W-1:0] id_inst
);

    fetchState_e       r_state;
    fetchState_e       w_nextState;

    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_pcNext;
    logic              w_pcWen;
    logic [PC_W-1:0]   w_pcPlus4;

    logic [PC_W-1:0]   w_idPc;
    logic              w_idPcWen;
    logic [INST_W-1:0] w_idInst;
    logic [INST_W-1:0] w_idInstNext;
    logic              w_idInstWen;

    logic              w_misalign;
    logic              w_reqFire;

`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    logic              w_misFlag;
    logic              w_misFlagNext;
    logic              w_misFlagWen;

    assign w_misalign = (w_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_pcPlus4      = w_pc + PC_W'(4);
    assign imem_req_valid = (r_state == ST_REQ) && !rst && !w_misalign;
    assign imem_req_addr  = w_pc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign id_valid       = (r_state == ST_OUT) && !rst;
    assign id_pc          = w_idPc;
    assign id_inst        = w_idInst;

    // State register; reset abandons any outstanding fetch without a drop phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and register-load decisions; a redirect always overrides.
    always_comb begin
        w_nextState  = r_state;
        w_pcWen      = 1'b0;
        w_pcNext     = w_pcPlus4;
        w_idPcWen    = 1'b0;
        w_idInstWen  = 1'b0;
        w_idInstNext = imem_resp_data;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
        w_misFlagWen  = 1'b0;
        w_misFlagNext = 1'b0;
`endif
        if (redirect_valid) begin
            w_pcWen  = 1'b1;
            w_pcNext = redirect_pc;
        end
        case (r_state)
            ST_REQ: begin
                if (redirect_valid) begin
                    if (w_reqFire) begin
                        w_nextState = ST_DROP;
                    end
                end else if (w_misalign) begin
                    w_nextState  = ST_OUT;
                    w_idPcWen    = 1'b1;
                    w_idInstWen  = 1'b1;
                    w_idInstNext = '0;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
                    w_misFlagWen  = 1'b1;
                    w_misFlagNext = 1'b1;
`endif
                end else if (imem_req_ready) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_nextState = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    w_nextState = ST_OUT;
                    w_pcWen     = 1'b1;
                    w_idPcWen   = 1'b1;
                    w_idInstWen = 1'b1;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
                    w_misFlagWen = 1'b1;
`endif
                end
            end
            ST_OUT: begin
                if (redirect_valid || id_ready) begin
                    w_nextState = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    w_nextState = ST_REQ;
                end
            end
            default: begin
                w_nextState = ST_REQ;
            end
        endcase
    end

    ysyx_22050550_Reg #(
        .WIDTH     (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pcReg (
        .clk    (clk),
        .rst    (rst),
        .i_wen  (w_pcWen),
        .i_din  (w_pcNext),
        .o_dout (w_pc)
    );

    ysyx_22050550_Reg #(
        .WIDTH     (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_idPcReg (
        .clk    (clk),
        .rst    (rst),
        .i_wen  (w_idPcWen),
        .i_din  (w_pc),
        .o_dout (w_idPc)
    );

    ysyx_22050550_Reg #(
        .WIDTH     (INST_W),
        .RESET_VAL ('0)
    ) u_idInstReg (
        .clk    (clk),
        .rst    (rst),
        .i_wen  (w_idInstWen),
        .i_din  (w_idInstNext),
        .o_dout (w_idInst)
    );

`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    ysyx_22050550_Reg #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_misFlagReg (
        .clk    (clk),
        .rst    (rst),
        .i_wen  (w_misFlagWen),
        .i_din  (w_misFlagNext),
        .o_dout (w_misFlag)
    );

    assign id_misalign = id_valid && w_misFlag;
`endif

endmodule

// File: tb/tb_ysyx_22050550_fetch_ctrl.sv
// Scoreboard bench for the fetch controller: directed scenarios push the
// expected request addresses and decode hand-offs, a memory model answers
// fetches, and a monitor compares whatever the controller presents.
module tb_ysyx_22050550_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] addr;
        int          gap;
    } addrExp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } idExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
    logic        id_misalign;
`endif

    addrExp_t    expAddrQ[$];
    idExp_t      expIdQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          granted = 0;
    int          used = 0;
    int          respDelay = 0;
    logic        memPending = 1'b0;
    int          memCnt = 0;
    logic [63:0] memAddr = 64'd0;

    ysyx_22050550_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
        .id_misalign     (id_misalign),
`endif
        .id_inst         (id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instFor(input logic [63:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for the controller", name);
    endtask

    task automatic pushAddr(input logic [63:0] a, input int gap);
        addrExp_t e;
        e.addr = a;
        e.gap  = gap;
        expAddrQ.push_back(e);
    endtask

    task automatic pushId(input logic [63:0] pc, input logic [31:0] inst, input logic mis);
        idExp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.mis  = mis;
        expIdQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic waitUsed(input int target, input string name);
        int n = 0;
        while (used < target && n < 50) begin
            tick();
            n++;
        end
        if (used < target) reportTimeout(name);
    endtask

    task automatic waitIdValid(input string name);
        int n = 0;
        while (!id_valid && n < 50) begin
            tick();
            n++;
        end
        if (!id_valid) reportTimeout(name);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expAddrQ.size() != 0 || expIdQ.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (expAddrQ.size() != 0 || expIdQ.size() != 0) begin
            reportTimeout(name);
            expAddrQ.delete();
            expIdQ.delete();
        end
    endtask

    // Memory model: grants requests while credits remain and answers each
    // accepted fetch respDelay cycles after the WAIT cycle begins.
    initial begin
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (rst) begin
                memPending = 1'b0;
            end else if (memPending) begin
                if (memCnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = instFor(memAddr);
                    memPending      = 1'b0;
                end else begin
                    memCnt--;
                end
            end
            imem_req_ready = (granted > used);
            if (!rst && imem_req_valid && imem_req_ready) begin
                used++;
                memPending = 1'b1;
                memCnt     = respDelay;
                memAddr    = imem_req_addr;
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pops on each handshake.
    initial begin
        int          cycle = 0;
        int          lastAccept = 0;
        logic        prevRst = 1'b0;
        logic        prevRedirect = 1'b0;
        logic        prevIdValid = 1'b0;
        logic        prevIdReady = 1'b0;
        logic [63:0] prevPc = 64'd0;
        logic [31:0] prevInst = 32'd0;
        addrExp_t    ea;
        idExp_t      ei;
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            if (rst) begin
                checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
                checkOutput("rst_id_valid", 64'(id_valid), 64'd0);
                if (prevRst) begin
                    checkOutput("rst_id_pc", id_pc, RESET_PC);
                    checkOutput("rst_id_inst", 64'(id_inst), 64'd0);
                end
            end else begin
                if (prevRst) begin
                    checkOutput("first_req_valid", 64'(imem_req_valid), 64'd1);
                    checkOutput("first_req_addr", imem_req_addr, RESET_PC);
                end
                if (prevRedirect) checkOutput("id_valid_after_redirect", 64'(id_valid), 64'd0);
                if (prevIdValid && !prevIdReady && !prevRedirect && !prevRst) begin
                    checkOutput("hold_id_valid", 64'(id_valid), 64'd1);
                    checkOutput("hold_id_pc", id_pc, prevPc);
                    checkOutput("hold_id_inst", 64'(id_inst), 64'(prevInst));
                end
                if (id_valid) checkOutput("no_req_while_out", 64'(imem_req_valid), 64'd0);
                if (imem_req_valid && imem_req_ready) begin
                    if (expAddrQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_req: got 0x%0h, expected no request", imem_req_addr);
                    end else begin
                        ea = expAddrQ.pop_front();
                        checkOutput("req_addr", imem_req_addr, ea.addr);
                        if (ea.gap != 0) checkOutput("req_spacing", 64'(cycle - lastAccept), 64'(ea.gap));
                    end
                    lastAccept = cycle;
                end
                if (id_valid && id_ready && !redirect_valid) begin
                    if (expIdQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_id: got pc 0x%0h, expected no instruction", id_pc);
                    end else begin
                        ei = expIdQ.pop_front();
                        checkOutput("id_pc", id_pc, ei.pc);
                        checkOutput("id_inst", 64'(id_inst), 64'(ei.inst));
`ifdef YSYX_22050550_FETCH_MISALIGN_EN
                        checkOutput("id_misalign", 64'(id_misalign), 64'(ei.mis));
`endif
                    end
                end
            end
            prevRst      = rst;
            prevRedirect = redirect_valid;
            prevIdValid  = id_valid;
            prevIdReady  = id_ready;
            prevPc       = id_pc;
            prevInst     = id_inst;
        end
    end

    // Directed scenarios.
    initial begin
        int base;
        repeat (3) tick();

        $display("[TB] back-to-back fetches after reset");
        pushAddr(64'h8000_0000, 0);
        pushAddr(64'h8000_0004, 3);
        pushAddr(64'h8000_0008, 3);
        pushId(64'h8000_0000, instFor(64'h8000_0000), 1'b0);
        pushId(64'h8000_0004, instFor(64'h8000_0004), 1'b0);
        pushId(64'h8000_0008, instFor(64'h8000_0008), 1'b0);
        granted += 3;
        rst = 1'b0;
        waitDrain("seq_fetch");

        $display("[TB] decode stall");
        id_ready = 1'b0;
        pushAddr(64'h8000_000C, 0);
        pushAddr(64'h8000_0010, 0);
        pushId(64'h8000_000C, instFor(64'h8000_000C), 1'b0);
        pushId(64'h8000_0010, instFor(64'h8000_0010), 1'b0);
        granted += 2;
        waitIdValid("stall_out");
        repeat (4) tick();
        id_ready = 1'b1;
        waitDrain("stall");

        $display("[TB] redirect in WAIT, late response");
        respDelay = 2;
        base = granted;
        pushAddr(64'h8000_0014, 0);
        pushAddr(64'h8000_1000, 0);
        pushId(64'h8000_1000, instFor(64'h8000_1000), 1'b0);
        granted += 2;
        waitUsed(base + 1, "wait_redirect_accept");
        respDelay = 0;
        applyStimulus(64'h8000_1000);
        waitDrain("wait_redirect");

        $display("[TB] redirect and response together");
        base = granted;
        pushAddr(64'h8000_1004, 0);
        pushAddr(64'h8000_2000, 0);
        pushId(64'h8000_2000, instFor(64'h8000_2000), 1'b0);
        granted += 2;
        waitUsed(base + 1, "same_cycle_accept");
        applyStimulus(64'h8000_2000);
        waitDrain("same_cycle_redirect");

        $display("[TB] redirect in OUT");
        pushAddr(64'h8000_2004, 0);
        pushAddr(64'h8000_3000, 0);
        pushId(64'h8000_3000, instFor(64'h8000_3000), 1'b0);
        granted += 2;
        waitIdValid("out_redirect_valid");
        applyStimulus(64'h8000_3000);
        waitDrain("out_redirect");

        $display("[TB] redirect in REQ");
        applyStimulus(64'h8000_4000);
        pushAddr(64'h8000_4000, 0);
        pushId(64'h8000_4000, instFor(64'h8000_4000), 1'b0);
        granted += 1;
        waitDrain("req_redirect");
        pushAddr(64'h8000_4004, 0);
        pushAddr(64'h8000_5000, 0);
        pushId(64'h8000_5000, instFor(64'h8000_5000), 1'b0);
        granted += 2;
        applyStimulus(64'h8000_5000);
        waitDrain("req_redirect_accept");

        $display("[TB] reset during WAIT");
        respDelay = 3;
        base = granted;
        pushAddr(64'h8000_5004, 0);
        granted += 1;
        waitUsed(base + 1, "reset_accept");
        rst = 1'b1;
        tick();
        tick();
        respDelay = 0;
        pushAddr(RESET_PC, 0);
        pushId(RESET_PC, instFor(RESET_PC), 1'b0);
        granted += 1;
        rst = 1'b0;
        waitDrain("reset_wait");

`ifdef YSYX_22050550_FETCH_MISALIGN_EN
        $display("[TB] misaligned redirect");
        id_ready = 1'b0;
        pushId(64'h8000_0002, 32'd0, 1'b1);
        pushAddr(64'h8000_0100, 0);
        pushId(64'h8000_0100, instFor(64'h8000_0100), 1'b0);
        applyStimulus(64'h8000_0002);
        granted += 1;
        tick();
        id_ready = 1'b1;
        tick();
        applyStimulus(64'h8000_0100);
        waitDrain("misalign");
`endif

        repeat (5) tick();
        checkOutput("credits_used", 64'(used), 64'(granted));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_22050550_fetch_ctrl.md
YSYX_22050550_FETCH_CTRL -- requirements
Module: ysyx_22050550_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 64, PC/address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 64'h80000000, first fetch address.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port redirect_valid  in  1  branch/jump/trap redirect request.
REQ-007 SHALL have port redirect_pc  in  PC_W  redirect target.
REQ-008 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr  out  PC_W  fetch address.
REQ-011 SHALL have port imem_resp_valid  in  1  fetch data valid.
REQ-012 SHALL have port imem_resp_data  in  INST_W  fetched instruction.
REQ-013 SHALL have port id_valid  out  1  instruction valid to decode.
REQ-014 SHALL have port id_ready  in  1  decode accepts instruction.
REQ-015 SHALL have port id_pc  out  PC_W  PC of presented instruction.
REQ-016 SHALL have port id_inst  out  INST_W  presented instruction.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, OUT, DROP; at most one outstanding fetch.
REQ-018 In REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go WAIT.
REQ-019 In WAIT: on imem_resp_valid capture data into id_inst, pc into id_pc, pc<=pc+4 (mod 2^PC_W), go OUT.
REQ-020 In OUT: id_valid=1, id_pc/id_inst stable until id_ready; on id_ready go REQ.
REQ-021 In DROP: on imem_resp_valid discard data, go REQ; no id_valid.
REQ-022 Minimum throughput one instruction per 3 cycles (REQ, WAIT, OUT with immediate ready/resp).
REQ-023 redirect_valid has priority over every other event; pc<=redirect_pc in all cases.
REQ-024 Redirect in REQ without accept: stay REQ, new address next cycle; with accept same cycle: go DROP.
REQ-025 Redirect in WAIT without resp: go DROP; with resp same cycle: discard resp, go REQ.
REQ-026 Redirect in OUT: id_valid=0 next cycle, held instruction discarded even if id_ready same cycle, go REQ.
REQ-027 Redirect in DROP: update pc, remain DROP until the pending response arrives.
REQ-028 imem_resp_valid in REQ or OUT SHALL be ignored.

Reset
REQ-029 rst SHALL set state=REQ, pc=RESET_PC, id_valid=0, id_pc=RESET_PC, id_inst=0, imem_req_valid=0 during reset.
REQ-030 rst mid-fetch SHALL abandon the outstanding fetch without a DROP phase; memory is reset in the same cycle.
REQ-031 First request SHALL issue in the first cycle after rst deasserts, address RESET_PC.

Configuration
REQ-032 Macro YSYX_22050550_FETCH_MISALIGN_EN defined: output port id_misalign (1 bit) exists; in REQ with pc[1:0]!=0 no request issues, go OUT with id_inst=0, id_misalign=1, pc unchanged.
REQ-033 Macro undefined: no id_misalign port; pc[1:0] ignored, request issues unconditionally.

Structure
REQ-034 Shared define file SHALL hold state encodings, RESET_PC value, INST_W/PC_W defaults.
REQ-035 pc, id_pc and id_inst SHALL be held in instances of ysyx_22050550_Reg; no other sub-module.

Verification
REQ-036 Reset release, ready/resp immediate, id_ready=1 -> addrs 0x80000000, 0x80000004, 0x80000008 at 3-cycle spacing, id_pc matches.
REQ-037 id_ready=0 for 5 cycles in OUT -> id_valid, id_pc, id_inst stable; no new request until ready.
REQ-038 Redirect to 0x80001000 in WAIT, resp 2 cycles later -> resp discarded, next req addr 0x80001000, no id_valid for stale inst.
REQ-039 Redirect and resp same cycle in WAIT -> no id_valid, next req addr = redirect_pc.
REQ-040 rst asserted in WAIT -> next req at 0x80000000, id_valid=0.
REQ-041 With FETCH_MISALIGN_EN, redirect to 0x80000002 -> no imem request, id_valid=1, id_misalign=1, id_pc=0x80000002.
